// File: rtl/puertas_pkg.sv
// Shared types and encodings for the elevator door controller.
// State enum plus the command, status and actuator codes used by the algorithm block.
package puertas_pkg;

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABRIENDO = 3'd1,
    ABIERTA  = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } estado_t;

  // Command codes on orden; 2'b11 is reserved and behaves as ORD_NADA.
  localparam logic [1:0] ORD_NADA   = 2'b00;
  localparam logic [1:0] ORD_ABRIR  = 2'b01;
  localparam logic [1:0] ORD_CERRAR = 2'b10;

  // Status codes returned on estado_puertas.
  localparam logic [1:0] EP_CERRADA  = 2'b00;
  localparam logic [1:0] EP_ABRIENDO = 2'b01;
  localparam logic [1:0] EP_ABIERTA  = 2'b10;
  localparam logic [1:0] EP_CERRANDO = 2'b11;

  // Door motor commands.
  localparam logic [1:0] ACT_PARO   = 2'b00;
  localparam logic [1:0] ACT_ABRIR  = 2'b01;
  localparam logic [1:0] ACT_CERRAR = 2'b10;

  // FALLA reports as closing so the algorithm never treats a faulted door as usable.
  function automatic logic [1:0] codigo_estado(estado_t e);
    logic [1:0] c;
    c = EP_CERRANDO;
    unique case (e)
      CERRADA:  c = EP_CERRADA;
      ABRIENDO: c = EP_ABRIENDO;
      ABIERTA:  c = EP_ABIERTA;
      CERRANDO: c = EP_CERRANDO;
      default:  c = EP_CERRANDO;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] codigo_actuador(estado_t e);
    logic [1:0] c;
    c = ACT_PARO;
    unique case (e)
      ABRIENDO: c = ACT_ABRIR;
      CERRANDO: c = ACT_CERRAR;
      default:  c = ACT_PARO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable saturating up/down counter with a terminal flag.
// terminal is MAX when counting up and zero when counting down.
module temporizador #(
  parameter int unsigned MAX = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         carga,
  input  logic [$clog2(MAX + 1)-1:0]   valor,
  input  logic                         habilitar,
  input  logic                         subir,
  output logic                         terminal
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] TOPE = W'(MAX);

  logic [W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = valor;
    end else if (habilitar) begin
      if (subir) begin
        if (cuenta_q != TOPE) cuenta_d = cuenta_q + W'(1);
      end else begin
        if (cuenta_q != '0) cuenta_d = cuenta_q - W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign terminal = subir ? (cuenta_q == TOPE) : (cuenta_q == '0);

endmodule

// File: rtl/controlador_puertas.sv
// Door-side controller: turns the algorithm's door command into actuator drive,
// reports door status and raises the closed-and-locked interlock, obstruction and fault flags.
module controlador_puertas
  import puertas_pkg::*;
#(
  parameter int unsigned T_ABIERTA       = 16,
  parameter int unsigned T_MAX_MOV       = 64,
  parameter int unsigned MAX_REAPERTURAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] orden,
  input  logic       detenido,
  input  logic [1:0] boton_puertas,
  input  logic       sensor_puertas,
  input  logic       fin_abierta,
  input  logic       fin_cerrada,
  output logic [1:0] estado_puertas,
  output logic [1:0] actuador,
  output logic       cerrada,
  output logic       obstruccion,
  output logic       alarma
);

  localparam int unsigned W_AB   = $clog2(T_ABIERTA + 1);
  localparam int unsigned W_MOV  = $clog2(T_MAX_MOV + 1);
  localparam int unsigned W_REAP = $clog2(MAX_REAPERTURAS + 1);
  localparam logic [W_REAP-1:0] REAP_MAX = W_REAP'(MAX_REAPERTURAS);

  estado_t estado_q, estado_d;
  logic [W_REAP-1:0] reap_q, reap_d;

  logic apertura, cierre, reabrir;
  logic fin_carrera, fin_espera;
  logic carga_carrera, cuenta_carrera;
  logic carga_espera, cuenta_espera;

  assign apertura = detenido & ((orden == ORD_ABRIR) | boton_puertas[0]);
  assign cierre   = fin_espera | (orden == ORD_CERRAR) | boton_puertas[1];

  always_comb begin
    estado_d = estado_q;
    reabrir  = 1'b0;
    // Both limit switches at once means a broken sensor: trumps everything.
    if ((estado_q != FALLA) && fin_abierta && fin_cerrada) begin
      estado_d = FALLA;
    end else begin
      unique case (estado_q)
        CERRADA: begin
          if (apertura)         estado_d = ABRIENDO;
          else if (!fin_cerrada) estado_d = CERRANDO;
        end
        ABRIENDO: begin
          if (fin_abierta)      estado_d = ABIERTA;
          else if (fin_carrera) estado_d = FALLA;
        end
        ABIERTA: begin
          if (cierre && !sensor_puertas) estado_d = CERRANDO;
        end
        CERRANDO: begin
          if (fin_cerrada) begin
            estado_d = CERRADA;
          end else if (sensor_puertas || apertura) begin
            estado_d = ABRIENDO;
            reabrir  = 1'b1;
          end else if (fin_carrera) begin
            estado_d = FALLA;
          end
        end
        FALLA:   estado_d = FALLA;
        default: estado_d = FALLA;
      endcase
    end
  end

  // Stroke timer restarts from zero on every entry into a moving state.
  always_comb begin
    carga_carrera  = (estado_d != estado_q) && ((estado_d == ABRIENDO) || (estado_d == CERRANDO));
    cuenta_carrera = (estado_q == ABRIENDO) || (estado_q == CERRANDO);
    carga_espera   = (estado_d == ABIERTA) &&
                     ((estado_q != ABIERTA) || sensor_puertas || boton_puertas[0]);
    cuenta_espera  = (estado_q == ABIERTA);
  end

  always_comb begin
    reap_d = reap_q;
    if ((estado_d == CERRADA) && (estado_q != CERRADA)) begin
      reap_d = '0;
    end else if (reabrir && (reap_q != REAP_MAX)) begin
      reap_d = reap_q + W_REAP'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= CERRANDO;
      reap_q   <= '0;
    end else begin
      estado_q <= estado_d;
      reap_q   <= reap_d;
    end
  end

  temporizador #(
    .MAX (T_MAX_MOV)
  ) u_carrera (
    .clock     (clock),
    .reset     (reset),
    .carga     (carga_carrera),
    .valor     (W_MOV'(0)),
    .habilitar (cuenta_carrera),
    .subir     (1'b1),
    .terminal  (fin_carrera)
  );

  temporizador #(
    .MAX (T_ABIERTA)
  ) u_espera (
    .clock     (clock),
    .reset     (reset),
    .carga     (carga_espera),
    .valor     (W_AB'(T_ABIERTA)),
    .habilitar (cuenta_espera),
    .subir     (1'b0),
    .terminal  (fin_espera)
  );

  always_comb begin
    estado_puertas = codigo_estado(estado_q);
    actuador       = codigo_actuador(estado_q);
    cerrada        = (estado_q == CERRADA);
    alarma         = (estado_q == FALLA);
    obstruccion    = (reap_q == REAP_MAX);
  end

endmodule

// File: tb/tb_controlador_puertas.sv
// Bench for controlador_puertas: directed scenarios then randomized traffic,
// every cycle compared against a behavioural door model.
module tb_controlador_puertas;

  localparam int TA = 16;
  localparam int TM = 64;
  localparam int MR = 3;

  localparam int M_CERR = 0;
  localparam int M_ABR  = 1;
  localparam int M_ABI  = 2;
  localparam int M_CRR  = 3;
  localparam int M_FAL  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] orden = 2'b00;
  logic       detenido = 1'b0;
  logic [1:0] boton_puertas = 2'b00;
  logic       sensor_puertas = 1'b0;
  logic       fin_abierta = 1'b0;
  logic       fin_cerrada = 1'b0;
  logic [1:0] estado_puertas;
  logic [1:0] actuador;
  logic       cerrada;
  logic       obstruccion;
  logic       alarma;

  int checks = 0;
  int errors = 0;

  // Model state: phase, cycles spent in the current stroke, dwell left, reopen count.
  int fase, carrera, espera, reap;

  controlador_puertas #(
    .T_ABIERTA       (TA),
    .T_MAX_MOV       (TM),
    .MAX_REAPERTURAS (MR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .orden          (orden),
    .detenido       (detenido),
    .boton_puertas  (boton_puertas),
    .sensor_puertas (sensor_puertas),
    .fin_abierta    (fin_abierta),
    .fin_cerrada    (fin_cerrada),
    .estado_puertas (estado_puertas),
    .actuador       (actuador),
    .cerrada        (cerrada),
    .obstruccion    (obstruccion),
    .alarma         (alarma)
  );

  always #5 clock = ~clock;

  task automatic modelo_reset();
    fase = M_CRR; carrera = 0; espera = 0; reap = 0;
  endtask

  task automatic modelo_paso();
    bit apert, cierre;
    if (reset) begin
      modelo_reset();
      return;
    end
    apert = detenido && (orden == 2'b01 || boton_puertas[0]);
    if (fase != M_FAL && fin_abierta && fin_cerrada) begin
      fase = M_FAL;
      return;
    end
    case (fase)
      M_CERR: begin
        if (apert) begin fase = M_ABR; carrera = 0; end
        else if (!fin_cerrada) begin fase = M_CRR; carrera = 0; end
      end
      M_ABR: begin
        if (fin_abierta) begin fase = M_ABI; espera = TA; end
        else if (carrera >= TM) fase = M_FAL;
        else carrera++;
      end
      M_ABI: begin
        cierre = (espera == 0) || (orden == 2'b10) || boton_puertas[1];
        if (cierre && !sensor_puertas) begin fase = M_CRR; carrera = 0; end
        else if (sensor_puertas || boton_puertas[0]) espera = TA;
        else if (espera > 0) espera--;
      end
      M_CRR: begin
        if (fin_cerrada) begin fase = M_CERR; reap = 0; end
        else if (sensor_puertas || apert) begin
          fase = M_ABR; carrera = 0;
          if (reap < MR) reap++;
        end
        else if (carrera >= TM) fase = M_FAL;
        else carrera++;
      end
      default: ;
    endcase
  endtask

  function automatic logic [1:0] ep_esperado();
    case (fase)
      M_CERR:  return 2'b00;
      M_ABR:   return 2'b01;
      M_ABI:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] act_esperado();
    case (fase)
      M_ABR:   return 2'b01;
      M_CRR:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic comparar(input string tag, input logic [1:0] obs, input logic [1:0] esp);
    checks++;
    assert (obs === esp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, esp, $time);
    end
  endtask

  task automatic verificar();
    comparar("estado_puertas", estado_puertas, ep_esperado());
    comparar("actuador", actuador, act_esperado());
    comparar("cerrada", {1'b0, cerrada}, {1'b0, fase == M_CERR});
    comparar("alarma", {1'b0, alarma}, {1'b0, fase == M_FAL});
    comparar("obstruccion", {1'b0, obstruccion}, {1'b0, reap == MR});
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      modelo_paso();
      #1;
      verificar();
    end
  endtask

  task automatic poner(input logic det, input logic [1:0] ord, input logic [1:0] bot,
                       input logic sen, input logic fa, input logic fc);
    detenido = det; orden = ord; boton_puertas = bot;
    sensor_puertas = sen; fin_abierta = fa; fin_cerrada = fc;
  endtask

  // From a closed door: command open, short stroke, reach fully open.
  task automatic abrir();
    poner(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(2);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(1);
  endtask

  task automatic cerrar_boton();
    poner(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(2);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
  endtask

  task automatic pulso_reset();
    reset = 1'b1; ciclos(1);
    reset = 1'b0;
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
  endtask

  initial begin
    int en_falla;
    poner(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    modelo_reset();
    #1 verificar();
    comparar("reset_actuador", actuador, 2'b10);
    comparar("reset_estado", estado_puertas, 2'b11);
    ciclos(2);

    // Release reset, closed switch arrives on the second cycle.
    reset = 1'b0; ciclos(1);
    poner(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
    comparar("cerrada_tras_reset", {1'b0, cerrada}, 2'b01);

    // Full cycle with auto-close.
    poner(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(5);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); ciclos(1);
    ciclos(TA);
    comparar("aun_abierta", estado_puertas, 2'b10);
    ciclos(1);
    comparar("autocierre", actuador, 2'b10);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(3);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(2);

    // Three obstruction reopens.
    abrir();
    for (int k = 0; k < MR; k++) begin
      poner(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0); ciclos(1);
      poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(2);
      poner(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0); ciclos(1);
      poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); ciclos(1);
    end
    comparar("obstruccion_alta", {1'b0, obstruccion}, 2'b01);
    cerrar_boton();
    comparar("obstruccion_limpia", {1'b0, obstruccion}, 2'b00);

    // Close button while blocked holds the door open.
    abrir();
    poner(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0); ciclos(3);
    comparar("bloqueada_abierta", estado_puertas, 2'b10);
    poner(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);

    // Open button ignored while moving, then an opening stroke that times out.
    poner(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1); ciclos(3);
    poner(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(TM + 5);
    comparar("timeout_alarma", {1'b0, alarma}, 2'b01);
    pulso_reset();

    // Both limit switches in ABIERTA.
    abrir();
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1); ciclos(2);
    pulso_reset();

    // Asynchronous reset mid-opening.
    poner(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1); ciclos(1);
    poner(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); ciclos(3);
    #2 reset = 1'b1;
    #1 modelo_reset();
    verificar();
    ciclos(1);
    reset = 1'b0;
    ciclos(2);

    // Randomized traffic.
    en_falla = 0;
    for (int n = 0; n < 3000; n++) begin
      bit fa, fc;
      reset = ($urandom_range(0, 299) == 0) || (en_falla > 3);
      detenido = ($urandom_range(0, 3) != 0);
      orden = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      boton_puertas = {($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0)};
      sensor_puertas = ($urandom_range(0, 9) == 0);
      fa = (fase == M_ABR || fase == M_ABI) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 29) == 0);
      fc = (fase == M_CERR) ? ($urandom_range(0, 9) != 0)
         : (fase == M_CRR)  ? ($urandom_range(0, 4) == 0)
                            : ($urandom_range(0, 29) == 0);
      if (fa && fc && $urandom_range(0, 19) != 0) fa = 1'b0;
      fin_abierta = fa;
      fin_cerrada = fc;
      ciclos(1);
      en_falla = (fase == M_FAL) ? en_falla + 1 : 0;
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_puertas.md
Name: controlador_puertas

Overview:
Door-side controller for the elevator. It consumes the 2-bit door command that the main algorithm issues on `puertas` and drives the door actuator from the limit switches, the door buttons and the obstruction sensor. It returns the 2-bit `estado_puertas` status that the main algorithm reads back, plus a closed-and-locked interlock that permits cab motion. It sits between the algorithm block and the physical door plant.

Parameters:
T_ABIERTA, 16, clock cycles the door stays fully open before auto-close
T_MAX_MOV, 64, max clock cycles for an open or close stroke before fault
MAX_REAPERTURAS, 3, reopen count at which `obstruccion` asserts

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
orden  in  2  command from algorithm: 00 hold, 01 open, 10 close, 11 reserved (treated as hold)
detenido  in  1  cab stopped at floor; gates every open request
boton_puertas  in  2  bit0 open button, bit1 close button (level)
sensor_puertas  in  1  obstruction between doors
fin_abierta  in  1  limit switch, door fully open
fin_cerrada  in  1  limit switch, door fully closed
estado_puertas  out  2  00 closed, 01 opening, 10 open, 11 closing (11 also during FALLA)
actuador  out  2  door motor: 00 stop, 01 open, 10 close
cerrada  out  1  closed-and-locked interlock
obstruccion  out  1  repeated-obstruction warning
alarma  out  1  door fault

Behaviour:
- Moore FSM. All outputs decode from registered state/flags; a transition takes effect one cycle after the sampled inputs.
- States: CERRADA, ABRIENDO, ABIERTA, CERRANDO, FALLA.
- Reset (async):
  - state CERRANDO, so the door position is established safely.
  - Output values: actuador=10, estado_puertas=11, cerrada=0, obstruccion=0, alarma=0.
  - Counters cleared.
- Open request: `apertura = detenido & (orden==01 | boton_puertas[0])`.
- Limit-switch fault: fin_abierta & fin_cerrada both high in any non-FALLA state -> FALLA (highest priority).
- CERRADA:
  - Outputs: actuador=00, cerrada=1.
  - apertura -> ABRIENDO.
  - fin_cerrada drops without a request -> CERRANDO.
- ABRIENDO:
  - Outputs: actuador=01, stroke timer counts up.
  - fin_abierta -> ABIERTA, dwell timer loaded with T_ABIERTA.
  - Stroke timer reaches T_MAX_MOV -> FALLA.
- ABIERTA:
  - Outputs: actuador=00, dwell timer counts down, saturating at 0.
  - sensor_puertas or boton_puertas[0] reloads dwell to T_ABIERTA.
  - Close trigger = dwell==0 | orden==10 | boton_puertas[1].
  - Close trigger with sensor_puertas=0 -> CERRANDO, stroke timer cleared.
  - Close trigger with sensor blocked: stay in ABIERTA.
- CERRANDO:
  - Outputs: actuador=10, stroke timer counts up.
  - fin_cerrada -> CERRADA; wins over a same-cycle obstruction or open button.
  - Otherwise sensor_puertas or apertura -> ABRIENDO, reopen counter +1 (saturating).
  - Stroke timer reaches T_MAX_MOV -> FALLA.
- FALLA:
  - Outputs: actuador=00, alarma=1, cerrada=0.
  - Exit only by reset.
- Reopen counter:
  - When it reaches MAX_REAPERTURAS, `obstruccion`=1.
  - Counter and flag clear on entry to CERRADA.
- orden=11 behaves as 00.
- orden is a level, not a pulse: orden==01 held while in CERRADA keeps reopening after each close.
- Counter widths are $clog2(param+1). No wrap-around is permitted: all counters saturate.
- Reset asserted mid-stroke: immediate return to reset values; the next stroke is a close.

Decomposition:
- Package `puertas_pkg` holds:
  - state enum;
  - encodings for orden (ORD_NADA, ORD_ABRIR, ORD_CERRAR);
  - encodings for estado_puertas (EP_CERRADA, EP_ABRIENDO, EP_ABIERTA, EP_CERRANDO);
  - encodings for actuador (ACT_PARO, ACT_ABRIR, ACT_CERRAR).
- One sub-module `temporizador`: parameterised loadable saturating counter with load/enable/up-down and a terminal flag. It is instantiated twice, for stroke timeout and dwell.

Test Plan:
- Reset release, fin_cerrada=1 on cycle 2 -> estado 11 then 00 next cycle; cerrada=1, actuador=00.
- detenido=1, orden=01 one cycle, fin_abierta 5 cycles later -> actuador=01 for those cycles, estado 10, auto-close after 16 cycles -> actuador=10; fin_cerrada -> estado 00.
- In CERRANDO, sensor_puertas pulse, repeated 3 times -> each reopens (estado 01); obstruccion=1 after the 3rd; clears on reaching CERRADA.
- In ABIERTA, boton_puertas[1]=1 with sensor_puertas=1 -> stays 10, actuador=00; sensor drops -> CERRANDO next cycle.
- detenido=0, boton_puertas[0]=1 in CERRADA -> no change. Then ABRIENDO with fin_abierta held low 64 cycles -> alarma=1, actuador=00, stays in FALLA until reset.
- fin_abierta=fin_cerrada=1 while in ABIERTA -> FALLA next cycle. Reset asserted mid-ABRIENDO -> outputs return to reset values asynchronously.
